// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate game controller for the motion-controlled pong display.
// Once per frame it clamps the paddle, steps the ball, resolves wall and paddle
// bounces and misses, and keeps score and lives.
// Optional feature macro: PONG_SPEEDUP_EN (ball speeds up every fourth paddle hit).
module pong_game_ctrl #(
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_HALF  = 50,
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [9:0] display_x,
   output logic [9:0] paddle_x,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic       game_over,
   output logic       miss
);

   localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

   localparam logic signed [10:0] PAD_MIN     = 11'(PADDLE_HALF + 1);
   localparam logic signed [10:0] PAD_MAX     = 11'(638 - PADDLE_HALF);
   localparam logic signed [10:0] HIT_REACH   = 11'(PADDLE_HALF + 10);
   localparam logic signed [10:0] X_WALL_LO   = 11'sd10;
   localparam logic signed [10:0] X_WALL_HI   = 11'sd629;
   localparam logic signed [10:0] X_MIN       = 11'sd11;
   localparam logic signed [10:0] X_MAX       = 11'sd628;
   localparam logic signed [10:0] Y_WALL      = 11'sd10;
   localparam logic signed [10:0] Y_MIN       = 11'sd11;
   localparam logic signed [10:0] Y_HIT_TOP   = 11'sd440;
   localparam logic signed [10:0] Y_HIT_LINE  = 11'sd441;
   localparam logic signed [10:0] Y_MISS_LINE = 11'sd469;

   localparam logic [9:0] CENTRE_X   = 10'd320;
   localparam logic [9:0] CENTRE_Y   = 10'd240;
   localparam logic [1:0] LIVES_INIT = 2'(LIVES);

   typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

   state_t            state_q, state_nx;
   logic [CNT_W-1:0]  serve_cnt_q, serve_cnt_nx;
   logic              dx_neg_q, dx_neg_nx;
   logic              dy_up_q, dy_up_nx;
   logic              serve_neg_q, serve_neg_nx;
   logic [9:0]        paddle_nx, ball_x_nx, ball_y_nx;
   logic [7:0]        score_nx;
   logic [1:0]        lives_nx;
   logic              game_over_nx, miss_nx;
   logic              new_game, hit_take;
   logic [2:0]        speed;

   logic signed [10:0] step_s, bx_s, by_s, pad_s;
   logic signed [10:0] nx_s, x_new_s, dist_s, ny_up_s, ny_dn_s;
   logic               paddle_hit;

   function automatic logic [9:0] clamp_paddle(input logic [9:0] raw);
      logic signed [10:0] v;
      v = $signed({1'b0, raw});
      if (v < PAD_MIN)      return 10'(PAD_MIN);
      else if (v > PAD_MAX) return 10'(PAD_MAX);
      else                  return raw;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
      return (v < 11'sd0) ? -v : v;
   endfunction

`ifdef PONG_SPEEDUP_EN
   logic [2:0] speed_q;

   // Speed restarts each game and steps up on every fourth hit, capped at 6.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         speed_q <= 3'(BALL_SPEED);
      else if (new_game)
         speed_q <= 3'(BALL_SPEED);
      else if (hit_take && (score != 8'hFF) && (score_nx[1:0] == 2'b00) && (speed_q < 3'd6))
         speed_q <= speed_q + 3'd1;
   end

   assign speed = speed_q;
`else
   assign speed = 3'(BALL_SPEED);
`endif

   // Candidate ball motion for this frame, all in 11-bit signed space so
   // nothing wraps below 0 or above 1023.
   assign step_s  = $signed({8'd0, speed});
   assign bx_s    = $signed({1'b0, ball_x});
   assign by_s    = $signed({1'b0, ball_y});
   assign pad_s   = $signed({1'b0, paddle_x});
   assign nx_s    = dx_neg_q ? (bx_s - step_s) : (bx_s + step_s);
   assign x_new_s = (nx_s <= X_WALL_LO) ? X_MIN : ((nx_s >= X_WALL_HI) ? X_MAX : nx_s);
   assign dist_s  = x_new_s - pad_s;
   assign ny_up_s = by_s - step_s;
   assign ny_dn_s = by_s + step_s;
   assign paddle_hit = !dy_up_q && (by_s <= Y_HIT_TOP) && (ny_dn_s >= Y_HIT_LINE)
                       && (abs11(dist_s) <= HIT_REACH);

   // Next-state and register-update decode; everything holds unless a frame
   // tick or a start request says otherwise.
   always_comb begin
      state_nx     = state_q;
      serve_cnt_nx = serve_cnt_q;
      dx_neg_nx    = dx_neg_q;
      dy_up_nx     = dy_up_q;
      serve_neg_nx = serve_neg_q;
      paddle_nx    = paddle_x;
      ball_x_nx    = ball_x;
      ball_y_nx    = ball_y;
      score_nx     = score;
      lives_nx     = lives;
      game_over_nx = game_over;
      miss_nx      = 1'b0;
      new_game     = 1'b0;
      hit_take     = 1'b0;

      if (frame_tick)
         paddle_nx = clamp_paddle(display_x);

      case (state_q)
         IDLE, OVER: begin
            // start wins over a coincident frame tick: no counting that frame
            if (start) begin
               new_game     = 1'b1;
               state_nx     = SERVE;
               serve_cnt_nx = '0;
               score_nx     = 8'd0;
               lives_nx     = LIVES_INIT;
               game_over_nx = 1'b0;
               ball_x_nx    = CENTRE_X;
               ball_y_nx    = CENTRE_Y;
               serve_neg_nx = 1'b0;
            end
         end
         SERVE: begin
            if (frame_tick) begin
               if (serve_cnt_q == CNT_LAST) begin
                  state_nx     = PLAY;
                  dy_up_nx     = 1'b0;
                  dx_neg_nx    = serve_neg_q;
                  serve_neg_nx = ~serve_neg_q;
                  serve_cnt_nx = '0;
               end else begin
                  serve_cnt_nx = serve_cnt_q + CNT_W'(1);
               end
            end
         end
         PLAY: begin
            if (frame_tick) begin
               ball_x_nx = 10'(x_new_s);
               if (nx_s <= X_WALL_LO)
                  dx_neg_nx = 1'b0;
               else if (nx_s >= X_WALL_HI)
                  dx_neg_nx = 1'b1;

               if (dy_up_q) begin
                  if (ny_up_s <= Y_WALL) begin
                     ball_y_nx = 10'(Y_MIN);
                     dy_up_nx  = 1'b0;
                  end else begin
                     ball_y_nx = 10'(ny_up_s);
                  end
               end else if (paddle_hit) begin
                  // a hit takes priority over a miss in the same frame
                  hit_take  = 1'b1;
                  ball_y_nx = 10'(Y_HIT_TOP);
                  dy_up_nx  = 1'b1;
                  score_nx  = sat_inc8(score);
               end else if (ny_dn_s >= Y_MISS_LINE) begin
                  miss_nx   = 1'b1;
                  ball_x_nx = CENTRE_X;
                  ball_y_nx = CENTRE_Y;
                  if (lives <= 2'd1) begin
                     lives_nx     = 2'd0;
                     state_nx     = OVER;
                     game_over_nx = 1'b1;
                  end else begin
                     lives_nx     = lives - 2'd1;
                     state_nx     = SERVE;
                     serve_cnt_nx = '0;
                  end
               end else begin
                  ball_y_nx = 10'(ny_dn_s);
               end
            end
         end
      endcase
   end

   // Game state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_nx;
   end

   // Positions, directions, counters and outputs; reset restores everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         serve_cnt_q <= '0;
         dx_neg_q    <= 1'b0;
         dy_up_q     <= 1'b0;
         serve_neg_q <= 1'b0;
         paddle_x    <= CENTRE_X;
         ball_x      <= CENTRE_X;
         ball_y      <= CENTRE_Y;
         score       <= 8'd0;
         lives       <= LIVES_INIT;
         game_over   <= 1'b0;
         miss        <= 1'b0;
      end else begin
         serve_cnt_q <= serve_cnt_nx;
         dx_neg_q    <= dx_neg_nx;
         dy_up_q     <= dy_up_nx;
         serve_neg_q <= serve_neg_nx;
         paddle_x    <= paddle_nx;
         ball_x      <= ball_x_nx;
         ball_y      <= ball_y_nx;
         score       <= score_nx;
         lives       <= lives_nx;
         game_over   <= game_over_nx;
         miss        <= miss_nx;
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: hand-derived vector table for the opening of a
// game, then a frame-level reference model feeding a scoreboard queue through
// full games, game over, restart and a mid-frame reset.
module tb_pong_game_ctrl;

   localparam int BALL_SPEED   = 2;
   localparam int PADDLE_HALF  = 50;
   localparam int LIVES        = 3;
   localparam int SERVE_FRAMES = 60;

   localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_OVER = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic [9:0] display_x = 10'd0;
   logic [9:0] paddle_x, ball_x, ball_y;
   logic [7:0] score;
   logic [1:0] lives;
   logic       game_over, miss;

   pong_game_ctrl #(
      .BALL_SPEED(BALL_SPEED), .PADDLE_HALF(PADDLE_HALF),
      .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
      .display_x(display_x), .paddle_x(paddle_x), .ball_x(ball_x),
      .ball_y(ball_y), .score(score), .lives(lives),
      .game_over(game_over), .miss(miss)
   );

   always #5 clk = ~clk;

   typedef struct {
      int px; int bx; int by; int sc; int lv; int go; int ms;
   } exp_t;

   typedef struct {
      bit st; bit tk; int raw; int reps;
      int px; int bx; int by; int sc; int lv; int go;
   } vec_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // reference model state
   int m_state, m_px, m_bx, m_by, m_dx, m_dy, m_cnt;
   int m_sc, m_lv, m_go, m_ms, m_sdx, m_spd;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check({tag, ".paddle_x"},  int'(paddle_x),  e.px);
      check({tag, ".ball_x"},    int'(ball_x),    e.bx);
      check({tag, ".ball_y"},    int'(ball_y),    e.by);
      check({tag, ".score"},     int'(score),     e.sc);
      check({tag, ".lives"},     int'(lives),     e.lv);
      check({tag, ".game_over"}, int'(game_over), e.go);
      check({tag, ".miss"},      int'(miss),      e.ms);
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_px = 320; m_bx = 320; m_by = 240;
      m_dx = 1; m_dy = 1; m_cnt = 0; m_sc = 0; m_lv = LIVES;
      m_go = 0; m_ms = 0; m_sdx = 1; m_spd = BALL_SPEED;
   endtask

   function automatic int clampi(input int v);
      if (v < PADDLE_HALF + 1) return PADDLE_HALF + 1;
      if (v > 638 - PADDLE_HALF) return 638 - PADDLE_HALF;
      return v;
   endfunction

   // One clock edge of the game as described by its rules.
   task automatic model_edge(input bit st, input bit tk, input int raw);
      int old_px, nx, ny, d;
      old_px = m_px;
      m_ms   = 0;
      if (tk) m_px = clampi(raw);
      if ((m_state == S_IDLE || m_state == S_OVER) && st) begin
         m_state = S_SERVE; m_cnt = 0; m_sc = 0; m_lv = LIVES; m_go = 0;
         m_bx = 320; m_by = 240; m_sdx = 1; m_spd = BALL_SPEED;
      end else if (tk && m_state == S_SERVE) begin
         if (m_cnt == SERVE_FRAMES - 1) begin
            m_state = S_PLAY; m_dy = 1; m_dx = m_sdx; m_sdx = -m_sdx; m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end else if (tk && m_state == S_PLAY) begin
         nx = m_bx + m_dx * m_spd;
         if (nx <= 10)       begin m_bx = 11;  m_dx = 1;  end
         else if (nx >= 629) begin m_bx = 628; m_dx = -1; end
         else                m_bx = nx;
         d = m_bx - old_px;
         if (d < 0) d = -d;
         if (m_dy < 0) begin
            ny = m_by - m_spd;
            if (ny <= 10) begin m_by = 11; m_dy = 1; end
            else m_by = ny;
         end else if (m_by <= 440 && m_by + m_spd >= 441 && d <= PADDLE_HALF + 10) begin
            m_by = 440; m_dy = -1;
            if (m_sc < 255) begin
               m_sc++;
`ifdef PONG_SPEEDUP_EN
               if ((m_sc % 4) == 0 && m_spd < 6) m_spd++;
`endif
            end
         end else if (m_by + m_spd >= 469) begin
            m_ms = 1; m_lv--; m_bx = 320; m_by = 240;
            if (m_lv == 0) begin m_state = S_OVER; m_go = 1; end
            else begin m_state = S_SERVE; m_cnt = 0; end
         end else begin
            m_by = m_by + m_spd;
         end
      end
   endtask

   // Drive one cycle at a falling edge, queue the model's expectation, and
   // compare at the next falling edge.
   task automatic step(input string tag, input bit st, input bit tk, input int raw);
      exp_t e, g;
      start      = st;
      frame_tick = tk;
      display_x  = 10'(raw);
      model_edge(st, tk, raw);
      e.px = m_px; e.bx = m_bx; e.by = m_by; e.sc = m_sc;
      e.lv = m_lv; e.go = m_go; e.ms = m_ms;
      sb_q.push_back(e);
      @(negedge clk);
      g = sb_q.pop_front();
      check_all(tag, g);
   endtask

   // One frame: tick cycle plus a quiet cycle (miss must drop again).
   task automatic frame(input string tag, input int raw);
      step(tag, 1'b0, 1'b1, raw);
      step(tag, 1'b0, 1'b0, raw);
   endtask

   vec_t tbl[13];
   exp_t rst_e;

   initial begin
      int nframes;
      int raw;

      // st tk raw reps | paddle ball_x ball_y score lives game_over
      tbl[0]  = '{1'b0, 1'b1, 700, 1,  588, 320, 240, 0, 3, 0};
      tbl[1]  = '{1'b0, 1'b1, 0,   1,  51,  320, 240, 0, 3, 0};
      tbl[2]  = '{1'b0, 1'b0, 300, 1,  51,  320, 240, 0, 3, 0};
      tbl[3]  = '{1'b1, 1'b0, 300, 1,  51,  320, 240, 0, 3, 0};
      tbl[4]  = '{1'b0, 1'b1, 300, 59, 300, 320, 240, 0, 3, 0};
      tbl[5]  = '{1'b0, 1'b1, 300, 1,  300, 320, 240, 0, 3, 0};
      tbl[6]  = '{1'b0, 1'b1, 300, 1,  300, 322, 242, 0, 3, 0};
      tbl[7]  = '{1'b0, 1'b0, 900, 1,  300, 322, 242, 0, 3, 0};
      tbl[8]  = '{1'b0, 1'b1, 500, 98, 500, 518, 438, 0, 3, 0};
      tbl[9]  = '{1'b0, 1'b1, 500, 1,  500, 520, 440, 0, 3, 0};
      tbl[10] = '{1'b0, 1'b1, 500, 1,  500, 522, 440, 1, 3, 0};
      tbl[11] = '{1'b0, 1'b1, 500, 1,  500, 524, 438, 1, 3, 0};
      tbl[12] = '{1'b1, 1'b0, 500, 1,  500, 524, 438, 1, 3, 0};

      rst_e = '{320, 320, 240, 0, LIVES, 0, 0};

      // reset state while reset is held
      model_reset();
      @(negedge clk);
      check_all("reset", rst_e);
      reset = 1'b1;

      // opening of a game from hand-derived vectors
      for (int i = 0; i < 13; i++) begin
         for (int r = 0; r < tbl[i].reps; r++)
            step($sformatf("vec%0d", i), tbl[i].st, tbl[i].tk, tbl[i].raw);
         check($sformatf("tbl%0d.paddle_x", i), int'(paddle_x), tbl[i].px);
         check($sformatf("tbl%0d.ball_x", i),   int'(ball_x),   tbl[i].bx);
         check($sformatf("tbl%0d.ball_y", i),   int'(ball_y),   tbl[i].by);
         check($sformatf("tbl%0d.score", i),    int'(score),    tbl[i].sc);
         check($sformatf("tbl%0d.lives", i),    int'(lives),    tbl[i].lv);
         check($sformatf("tbl%0d.game_over", i),int'(game_over),tbl[i].go);
      end
      step("idle_start", 1'b0, 1'b0, 500);

      // play on: track the ball for several hits (walls, ceiling, serves of
      // alternating direction), then stay away from it until game over
      nframes = 0;
      while (m_state != S_OVER && nframes < 8000) begin
         if (m_sc < 6) raw = m_bx;
         else          raw = (m_bx < 320) ? 1023 : 0;
         frame("play", raw);
         nframes++;
      end
      check("game_over_reached", int'(game_over), 1);
      check("lives_at_over", int'(lives), 0);

      // OVER: ball frozen, paddle still follows
      for (int i = 0; i < 4; i++) frame("over", 100 + 150 * i);
      check("over_frozen_x", int'(ball_x), 320);
      check("over_frozen_y", int'(ball_y), 240);

      // start coincident with a tick: new game, that frame does no counting
      step("restart", 1'b1, 1'b1, 400);
      check("restart_lives", int'(lives), LIVES);
      check("restart_score", int'(score), 0);
      check("restart_go", int'(game_over), 0);
      for (int i = 0; i < SERVE_FRAMES; i++) frame("reserve", 400);
      check("reserve_held_x", int'(ball_x), 320);
      frame("reserve", 400);
      check("reserve_first_x", int'(ball_x), 320 + BALL_SPEED);
      check("reserve_first_y", int'(ball_y), 240 + BALL_SPEED);
      for (int i = 0; i < 20; i++) frame("replay", 1023);

      // reset asserted mid-frame with a tick pending
      frame_tick = 1'b1;
      display_x  = 10'd10;
      #2 reset = 1'b0;
      #1 check_all("async_reset", rst_e);
      @(posedge clk);
      @(negedge clk);
      check_all("reset_hold", rst_e);
      model_reset();
      reset      = 1'b1;
      frame_tick = 1'b0;
      frame("post_reset", 10);
      step("post_reset_start", 1'b1, 1'b0, 10);
      for (int i = 0; i < SERVE_FRAMES + 10; i++) frame("post_reset_play", 610);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
